// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a multiplexed 7-segment scan: debounces each digit slot and rebuilds the 32-bit word.
// Optional dp capture per digit is enabled by defining SEG7_DECODE_DP_EN.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 262144
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  seg_i,
    input  logic [7:0]  sel_i,
    output logic [31:0] word_o,
    output logic        valid_o,
    output logic [7:0]  dp_o,
    output logic        seg_err_o,
    output logic        timeout_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
`ifdef SEG7_DECODE_DP_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
`endif

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_STABLE  = 2'd1,
        ST_LATCHED = 2'd2
    } state_t;

    // Returns {legal, nibble} for an active-low segment pattern (dp excluded).
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        case (pat)
            7'h40:   seg_decode = 5'h10;
            7'h79:   seg_decode = 5'h11;
            7'h24:   seg_decode = 5'h12;
            7'h30:   seg_decode = 5'h13;
            7'h19:   seg_decode = 5'h14;
            7'h12:   seg_decode = 5'h15;
            7'h02:   seg_decode = 5'h16;
            7'h78:   seg_decode = 5'h17;
            7'h00:   seg_decode = 5'h18;
            7'h10:   seg_decode = 5'h19;
            7'h08:   seg_decode = 5'h1A;
            7'h03:   seg_decode = 5'h1B;
            7'h46:   seg_decode = 5'h1C;
            7'h21:   seg_decode = 5'h1D;
            7'h06:   seg_decode = 5'h1E;
            7'h0E:   seg_decode = 5'h1F;
            default: seg_decode = 5'h00;
        endcase
    endfunction

    logic [SW-1:0]      seg_q;
    logic [7:0]         sel_q;
    logic [SW+7:0]      key_s, key_q;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7:0]         mask_q, mask_d;
    logic [7:0][3:0]    slot_q, slot_d;
    logic [TW-1:0]      to_cnt_q;
    logic [31:0]        word_q;
    logic               valid_q, seg_err_q, timeout_q;
    logic [7:0]         nsel_s;
    logic               elig_s, same_s, acc_s, done_s;
    logic [2:0]         idx_s;
    logic [4:0]         dec_s;

`ifndef SEG7_DECODE_DP_EN
    logic unused_dp_s;
    assign unused_dp_s = seg_i[7];
`endif

    assign key_s = {seg_q, sel_q};

    // Sample qualification: one-hot select check, slot index and pattern decode.
    always_comb begin
        nsel_s = ~sel_q;
        elig_s = (nsel_s != 8'h00) && ((nsel_s & (nsel_s - 8'd1)) == 8'h00);
        same_s = (key_s == key_q);
        idx_s  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (nsel_s[i]) begin
                idx_s = 3'(i);
            end else begin
                idx_s = idx_s;
            end
        end
        dec_s = seg_decode(seg_q[6:0]);
    end

    // Debounce FSM next-state: counts consecutive identical eligible samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_s   = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (elig_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = CW'(0);
                end
            end
            ST_STABLE: begin
                if (same_s) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (elig_s) begin
                    cnt_d = CW'(1);
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CW'(0);
                end
            end
            ST_LATCHED: begin
                if (same_s) begin
                    state_d = ST_LATCHED;
                end else if (elig_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = CW'(1);
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CW'(0);
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = CW'(0);
            end
        endcase
        if ((state_d == ST_STABLE) && (cnt_d == CW'(STABLE_CYCLES))) begin
            acc_s   = 1'b1;
            state_d = ST_LATCHED;
        end else begin
            acc_s   = 1'b0;
        end
    end

    // Slot/mask update for a legal accept; completion is the accept that fills the mask.
    always_comb begin
        slot_d = slot_q;
        mask_d = mask_q;
        if (acc_s && dec_s[4]) begin
            slot_d[idx_s] = dec_s[3:0];
            mask_d        = mask_q | (8'd1 << idx_s);
        end else begin
            mask_d = mask_q;
        end
        done_s = acc_s && dec_s[4] && (mask_d == 8'hFF);
    end

    // Input sample register and debounce state.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            seg_q   <= {SW{1'b1}};
            sel_q   <= 8'hFF;
            key_q   <= {(SW + 8){1'b1}};
            state_q <= ST_WAIT;
            cnt_q   <= CW'(0);
        end else begin
            seg_q   <= seg_i[SW-1:0];
            sel_q   <= sel_i;
            key_q   <= key_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Frame assembly, partial-frame timeout and registered pulses; an accept beats a timeout.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mask_q    <= 8'h00;
            slot_q    <= 32'h0000_0000;
            to_cnt_q  <= TW'(0);
            word_q    <= 32'h0000_0000;
            valid_q   <= 1'b0;
            seg_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            valid_q   <= done_s;
            seg_err_q <= acc_s && !dec_s[4];
            timeout_q <= 1'b0;
            if (acc_s) begin
                to_cnt_q <= TW'(0);
                mask_q   <= (done_s || !dec_s[4]) ? 8'h00 : mask_d;
            end else if (mask_q != 8'h00) begin
                if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    mask_q    <= 8'h00;
                    timeout_q <= 1'b1;
                    to_cnt_q  <= TW'(0);
                end else begin
                    to_cnt_q  <= to_cnt_q + TW'(1);
                end
            end else begin
                to_cnt_q <= TW'(0);
            end
            if (done_s) begin
                word_q <= slot_d;
            end else begin
                word_q <= word_q;
            end
        end
    end

`ifdef SEG7_DECODE_DP_EN
    logic [7:0] dp_slot_q, dp_slot_d, dp_q;

    // dp of the accepted digit, stored lit-high.
    always_comb begin
        dp_slot_d = dp_slot_q;
        if (acc_s && dec_s[4]) begin
            dp_slot_d[idx_s] = ~seg_q[7];
        end else begin
            dp_slot_d = dp_slot_q;
        end
    end

    // dp storage; the visible dp_o changes only with a completed frame.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            dp_slot_q <= 8'h00;
            dp_q      <= 8'h00;
        end else begin
            dp_slot_q <= dp_slot_d;
            dp_q      <= done_s ? dp_slot_d : dp_q;
        end
    end

    assign dp_o = dp_q;
`else
    assign dp_o = 8'h00;
`endif

    assign word_o    = word_q;
    assign valid_o   = valid_q;
    assign seg_err_o = seg_err_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: scenario tasks plus random scans against a run-length reference model.
module tb_seg7_scan_decoder;

    localparam int STABLE = 4;
    localparam int TMO    = 100;
`ifdef SEG7_DECODE_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seg = 8'hFF;
    logic [7:0]  sel = 8'hFF;
    logic [31:0] word_o;
    logic        valid_o, seg_err_o, timeout_o;
    logic [7:0]  dp_o;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .seg_i(seg), .sel_i(sel),
        .word_o(word_o), .valid_o(valid_o), .dp_o(dp_o),
        .seg_err_o(seg_err_o), .timeout_o(timeout_o)
    );

    int total = 0;
    int bad = 0;

    // reference model state: run length of identical samples, frame slots, last accept time
    int          step_no, last_acc, run;
    logic [15:0] m_key;
    logic [3:0]  m_slot [8];
    logic [7:0]  m_dps, m_mask, m_dp;
    logic [31:0] m_word;
    logic [42:0] exp_nxt, exp_now, act, last_act, last_exp;
    int          lane_mis, v_seen, e_seen, t_seen;
    logic [7:0]  prev_seg = 8'hFF;
    logic [7:0]  prev_sel = 8'hFF;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'h40; 4'h1: enc = 7'h79; 4'h2: enc = 7'h24; 4'h3: enc = 7'h30;
            4'h4: enc = 7'h19; 4'h5: enc = 7'h12; 4'h6: enc = 7'h02; 4'h7: enc = 7'h78;
            4'h8: enc = 7'h00; 4'h9: enc = 7'h10; 4'hA: enc = 7'h08; 4'hB: enc = 7'h03;
            4'hC: enc = 7'h46; 4'hD: enc = 7'h21; 4'hE: enc = 7'h06; 4'hF: enc = 7'h0E;
            default: enc = 7'h7F;
        endcase
    endfunction

    task automatic model_reset();
        step_no = 0; last_acc = 0; run = 1;
        m_key = DP_EN ? 16'hFFFF : 16'h7FFF;
        for (int i = 0; i < 8; i++) m_slot[i] = 4'h0;
        m_dps = 8'h00; m_mask = 8'h00; m_dp = 8'h00; m_word = 32'h0;
        exp_nxt = 43'd0;
    endtask

    // One registered sample: a run of STABLE identical one-hot samples is one accept.
    task automatic model_step(input logic [7:0] sg, input logic [7:0] sl);
        logic [15:0] key;
        logic [7:0]  nz;
        logic [3:0]  nib, nn;
        int          k;
        bit          legal, v, e, t;
        key = {sg, sl};
        if (!DP_EN) key[15] = 1'b0;
        step_no++;
        v = 1'b0; e = 1'b0; t = 1'b0;
        if (key == m_key) run++;
        else begin m_key = key; run = 1; end
        nz = ~sl;
        if ($countones(nz) == 1 && run == STABLE) begin
            k = 0;
            for (int i = 0; i < 8; i++) if (nz[i]) k = i;
            legal = 1'b0; nib = 4'h0;
            for (int n = 0; n < 16; n++) begin
                nn = n[3:0];
                if (enc(nn) == sg[6:0]) begin legal = 1'b1; nib = nn; end
            end
            last_acc = step_no;
            if (legal) begin
                m_slot[k] = nib; m_dps[k] = ~sg[7]; m_mask[k] = 1'b1;
                if (m_mask == 8'hFF) begin
                    for (int i = 0; i < 8; i++) m_word[4*i +: 4] = m_slot[i];
                    m_dp = DP_EN ? m_dps : 8'h00;
                    v = 1'b1; m_mask = 8'h00;
                end
            end else begin
                e = 1'b1; m_mask = 8'h00;
            end
        end else if (m_mask != 8'h00 && (step_no - last_acc) == TMO) begin
            m_mask = 8'h00; t = 1'b1;
        end
        exp_nxt = {m_word, m_dp, v, e, t};
    endtask

    task automatic clear_tallies();
        lane_mis = 0; v_seen = 0; e_seen = 0; t_seen = 0;
    endtask

    // Advance one cycle at the falling edge; the DUT is observed against the model's pipelined expectation.
    task automatic step(input logic [7:0] sg, input logic [7:0] sl);
        @(negedge clk);
        exp_now = exp_nxt;
        model_step(prev_seg, prev_sel);
        act = {word_o, dp_o, valid_o, seg_err_o, timeout_o};
        if (act !== exp_now) begin lane_mis++; last_act = act; last_exp = exp_now; end
        v_seen += int'(valid_o); e_seen += int'(seg_err_o); t_seen += int'(timeout_o);
        seg = sg; sel = sl; prev_seg = sg; prev_sel = sl;
    endtask

    task automatic hold(input logic [7:0] sg, input logic [7:0] sl, input int n);
        repeat (n) step(sg, sl);
    endtask

    task automatic digit(input int k, input logic [3:0] nib, input logic dp_lit, input int n);
        hold({~dp_lit, enc(nib)}, ~(8'd1 << k), n);
    endtask

    task automatic scan_range(input logic [31:0] w, input int lo, input int hi, input logic [7:0] dpm);
        for (int k = lo; k <= hi; k++) digit(k, w[4*k +: 4], dpm[k], 10);
    endtask

    task automatic flush();
        hold(8'hFF, 8'hFF, TMO + 10);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; seg = 8'hFF; sel = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        prev_seg = 8'hFF; prev_sel = 8'hFF;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({word_o, dp_o, valid_o, seg_err_o, timeout_o} !== 43'd0) begin
            bad++;
            $display("FAIL reset_state got %h want 0", {word_o, dp_o, valid_o, seg_err_o, timeout_o});
        end
    endtask

    task automatic test_scan();
        clear_tallies();
        scan_range(32'h12345678, 0, 7, 8'h00);
        scan_range(32'h12345678, 0, 7, 8'h00);
        total++; if (lane_mis !== 0) begin bad++; $display("FAIL scan_model mism=%0d got %h want %h", lane_mis, last_act, last_exp); end
        total++; if (word_o !== 32'h12345678) begin bad++; $display("FAIL scan_word got %h want 12345678", word_o); end
        total++; if (v_seen !== 2 || e_seen !== 0 || t_seen !== 0) begin bad++; $display("FAIL scan_pulses got v=%0d e=%0d t=%0d want 2/0/0", v_seen, e_seen, t_seen); end
    endtask

    task automatic test_glitch();
        clear_tallies();
        scan_range(32'h0, 0, 1, 8'h00);
        hold({1'b1, enc(4'h1)}, 8'hFB, STABLE - 1);
        scan_range(32'h0, 2, 7, 8'h00);
        total++; if (lane_mis !== 0) begin bad++; $display("FAIL glitch_model mism=%0d got %h want %h", lane_mis, last_act, last_exp); end
        total++; if (word_o !== 32'h0 || v_seen !== 1) begin bad++; $display("FAIL glitch_word got %h v=%0d want 00000000 v=1", word_o, v_seen); end
    endtask

    task automatic test_illegal();
        clear_tallies();
        scan_range(32'hDEADBEEF, 0, 4, 8'h00);
        hold(8'hFF, 8'hDF, 10);
        total++; if (e_seen !== 1 || v_seen !== 0) begin bad++; $display("FAIL illegal_err got e=%0d v=%0d want 1/0", e_seen, v_seen); end
        scan_range(32'hDEADBEEF, 0, 7, 8'h00);
        total++; if (word_o !== 32'hDEADBEEF || v_seen !== 1) begin bad++; $display("FAIL illegal_recover got %h v=%0d want deadbeef v=1", word_o, v_seen); end
        total++; if (lane_mis !== 0) begin bad++; $display("FAIL illegal_model mism=%0d got %h want %h", lane_mis, last_act, last_exp); end
    endtask

    task automatic test_timeout();
        flush();
        clear_tallies();
        scan_range(32'hCAFEF00D, 0, 3, 8'h00);
        hold(8'hFF, 8'hFF, TMO + 10);
        total++; if (t_seen !== 1 || v_seen !== 0) begin bad++; $display("FAIL timeout_pulse got t=%0d v=%0d want 1/0", t_seen, v_seen); end
        total++; if (word_o !== 32'hDEADBEEF) begin bad++; $display("FAIL timeout_word got %h want deadbeef", word_o); end
        total++; if (lane_mis !== 0) begin bad++; $display("FAIL timeout_model mism=%0d got %h want %h", lane_mis, last_act, last_exp); end
    endtask

    task automatic test_reset_mid();
        clear_tallies();
        scan_range(32'h0BADF00D, 0, 5, 8'h00);
        do_reset();
        total++; if (word_o !== 32'h0 || dp_o !== 8'h00) begin bad++; $display("FAIL midreset_state got %h/%h want 0/0", word_o, dp_o); end
        scan_range(32'h0BADF00D, 6, 7, 8'h00);
        total++; if (v_seen !== 0 || word_o !== 32'h0) begin bad++; $display("FAIL midreset_partial got %h v=%0d want 0 v=0", word_o, v_seen); end
        scan_range(32'h0BADF00D, 0, 7, 8'h00);
        total++; if (word_o !== 32'h0BADF00D) begin bad++; $display("FAIL midreset_recover got %h want 0badf00d", word_o); end
        total++; if (lane_mis !== 0) begin bad++; $display("FAIL midreset_model mism=%0d got %h want %h", lane_mis, last_act, last_exp); end
    endtask

    task automatic test_multi_sel_dp();
        flush();
        clear_tallies();
        scan_range(32'h600DCAFE, 0, 5, 8'h00);
        hold({1'b1, enc(4'h7)}, 8'hFC, 20);
        scan_range(32'h600DCAFE, 6, 7, 8'h00);
        total++; if (word_o !== 32'h600DCAFE || v_seen !== 1) begin bad++; $display("FAIL multisel_word got %h v=%0d want 600dcafe v=1", word_o, v_seen); end
        scan_range(32'h00000001, 0, 7, 8'h01);
        total++; if (dp_o !== (DP_EN ? 8'h01 : 8'h00) || word_o !== 32'h1) begin bad++; $display("FAIL dp_capture got dp=%h w=%h want dp=%h w=00000001", dp_o, word_o, DP_EN ? 8'h01 : 8'h00); end
        total++; if (lane_mis !== 0) begin bad++; $display("FAIL multisel_model mism=%0d got %h want %h", lane_mis, last_act, last_exp); end
    endtask

    task automatic test_random();
        int k, r, n;
        logic [7:0] sg, sl;
        clear_tallies();
        k = 0;
        repeat (250) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                hold(8'hFF, 8'hFF, TMO + 10);
            end else begin
                if (r < 80) k = (k + 1) % 8;
                else k = $urandom_range(0, 7);
                if ($urandom_range(0, 9) < 9) sg = {1'($urandom_range(0, 1)), enc(4'($urandom_range(0, 15)))};
                else sg = 8'($urandom);
                if ($urandom_range(0, 9) < 9) sl = ~(8'd1 << k);
                else sl = 8'($urandom);
                n = $urandom_range(1, 8);
                hold(sg, sl, n);
            end
        end
        hold(8'hFF, 8'hFF, 4);
        total++; if (lane_mis !== 0) begin bad++; $display("FAIL random_model mism=%0d got %h want %h", lane_mis, last_act, last_exp); end
    endtask

    initial begin
        model_reset();
        clear_tallies();
        repeat (3) @(posedge clk);
        test_reset();
        test_scan();
        test_glitch();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_multi_sel_dp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
